// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, RGB332 pixel type and the colour
// expansion used by the VGA output stage.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int CLK_DIV  = 2;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int COORD_W = 11;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Bit replication maps full-scale codes to 8'hFF and zero to 8'h00.
    function automatic rgb888_t expand_rgb332(input rgb332_t pix);
        rgb888_t res;
        res.r = {pix.r, pix.r, pix.r[2:1]};
        res.g = {pix.g, pix.g, pix.g[2:1]};
        res.b = {pix.b, pix.b, pix.b, pix.b};
        return res;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider plus horizontal/vertical position counters; emits the
// per-pixel strobe, the live coordinates and a start-of-frame pulse.
module vga_sync_counter #(
    parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic        clk,
    input  logic        resetN,
    output logic        pix_tick_o,
    output logic [10:0] pixel_x_o,
    output logic [10:0] pixel_y_o,
    output logic        start_of_frame_o
);
    import vga_timing_pkg::*;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic               sof_q, sof_d;
    logic               pix_tick;

    assign pix_tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        sof_d = 1'b0;
        if (pix_tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                // Line and frame wrap share this tick; the pulse lands on
                // the first clk that shows (0,0).
                if (v_q == V_LAST) begin
                    v_d   = '0;
                    sof_d = 1'b1;
                end else begin
                    v_d = v_q + COORD_W'(1);
                end
            end else begin
                h_d = h_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            sof_q <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            sof_q <= sof_d;
        end
    end

    assign pix_tick_o       = pix_tick;
    assign pixel_x_o        = h_q;
    assign pixel_y_o        = v_q;
    assign start_of_frame_o = sof_q;

endmodule

// File: rtl/vga_output_stage.sv
// Final VGA stage: timing generation, RGB332 sampling and expansion, with
// colour, syncs and blanking registered together one pixel behind pixelX/Y.
module vga_output_stage #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int CLK_DIV  = vga_timing_pkg::CLK_DIV
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        pixTick,
    output logic        startOfFrame,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N
);
    import vga_timing_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_VIS_END = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS_END = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic               pix_tick;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               sof;

    vga_sync_counter #(
        .H_TOTAL (H_TOT),
        .V_TOTAL (V_TOT),
        .CLK_DIV (CLK_DIV)
    ) u_sync_counter (
        .clk              (clk),
        .resetN           (resetN),
        .pix_tick_o       (pix_tick),
        .pixel_x_o        (h_cnt),
        .pixel_y_o        (v_cnt),
        .start_of_frame_o (sof)
    );

    logic    active_c;
    logic    hsync_n_c;
    logic    vsync_n_c;
    rgb888_t colour_c;

    always_comb begin
        active_c  = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        hsync_n_c = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
        vsync_n_c = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
        colour_c  = expand_rgb332(rgb332_t'(RGBIn));
    end

    logic    blank_n_q, blank_n_d;
    logic    hs_q, hs_d;
    logic    vs_q, vs_d;
    rgb888_t rgb_q, rgb_d;

    // The mux output for the current coordinates has settled by the last clk
    // of the pixel period, so everything is captured on the tick.
    always_comb begin
        blank_n_d = blank_n_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        rgb_d     = rgb_q;
        if (pix_tick) begin
            blank_n_d = active_c;
            hs_d      = hsync_n_c;
            vs_d      = vsync_n_c;
            rgb_d     = active_c ? colour_c : '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blank_n_q <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            rgb_q     <= '0;
        end else begin
            blank_n_q <= blank_n_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign pixelX       = h_cnt;
    assign pixelY       = v_cnt;
    assign pixTick      = pix_tick;
    assign startOfFrame = sof;
    assign VGA_R        = rgb_q.r;
    assign VGA_G        = rgb_q.g;
    assign VGA_B        = rgb_q.b;
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_BLANK_N  = blank_n_q;

endmodule

// File: tb/tb_vga_output_stage.sv
// Bench for vga_output_stage, run with a reduced raster so whole frames fit
// in a short simulation; the reference model works from pixel indices.
module tb_vga_output_stage;

    localparam int HA   = 20;
    localparam int HF   = 4;
    localparam int H_SW = 6;
    localparam int HB   = 4;
    localparam int VA   = 12;
    localparam int VF   = 2;
    localparam int V_SW = 2;
    localparam int VB   = 3;
    localparam int CD   = 2;
    localparam int HT   = HA + HF + H_SW + HB;
    localparam int VT   = VA + VF + V_SW + VB;
    localparam int FT   = HT * VT;

    logic        clk;
    logic        resetN;
    logic [7:0]  RGBIn;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        pixTick;
    logic        startOfFrame;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;

    vga_output_stage #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (H_SW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (V_SW), .V_BP (VB),
        .CLK_DIV  (CD)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .RGBIn        (RGBIn),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .pixTick      (pixTick),
        .startOfFrame (startOfFrame),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B),
        .VGA_HS       (VGA_HS),
        .VGA_VS       (VGA_VS),
        .VGA_BLANK_N  (VGA_BLANK_N)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [23:0] expand(input logic [7:0] v);
        int r, g, b;
        r = int'(v[7:5]);
        g = int'(v[4:2]);
        b = int'(v[1:0]);
        return {8'((r << 5) | (r << 2) | (r >> 1)),
                8'((g << 5) | (g << 2) | (g >> 1)),
                8'(b * 85)};
    endfunction

    // c = clk edges since reset release; rgb = RGBIn captured at the last tick.
    function automatic logic [50:0] model(input int c, input logic [7:0] rgb);
        int k, p, px, py;
        logic act, hs, vs;
        logic [23:0] col;
        k   = c / CD;
        act = 1'b0;
        hs  = 1'b1;
        vs  = 1'b1;
        col = 24'h0;
        if (k > 0) begin
            p   = k - 1;
            px  = p % HT;
            py  = (p / HT) % VT;
            act = (px < HA) && (py < VA);
            hs  = !((px >= HA + HF) && (px < HA + HF + H_SW));
            vs  = !((py >= VA + VF) && (py < VA + VF + V_SW));
            col = act ? expand(rgb) : 24'h0;
        end
        return {(c % CD) == (CD - 1), 11'(k % HT), 11'((k / HT) % VT),
                (k > 0) && (k % FT == 0) && (c % CD == 0), hs, vs, act, col};
    endfunction

    int         cyc      = 0;
    logic [7:0] tick_rgb = 8'h0;
    bit         mux_chk  = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!resetN) cyc = 0;
            else begin
                if ((cyc + 1) % CD == 0) tick_rgb = RGBIn;
                cyc++;
            end
        end
    end

    // Scoreboard: every clk, compare the full output bundle against the model.
    initial begin
        int c, k, px, py;
        forever begin
            @(negedge clk);
            c = resetN ? cyc : 0;
            check("cycle", 64'({pixTick, pixelX, pixelY, startOfFrame, VGA_HS, VGA_VS,
                                VGA_BLANK_N, VGA_R, VGA_G, VGA_B}), 64'(model(c, tick_rgb)));
            k = c / CD;
            if (mux_chk && k > 0) begin
                px = (k - 1) % HT;
                py = ((k - 1) / HT) % VT;
                if (px < HA && py < VA)
                    check("mux_colour", 64'({VGA_R, VGA_G, VGA_B}), 64'(expand(8'(px))));
            end
        end
    end

    // ---------------- driver ----------------
    int         mode      = 0;
    logic [7:0] const_rgb = 8'h0;

    // Models objects_mux: a new value appears within the clk after each edge.
    initial begin
        RGBIn = 8'h0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1:       RGBIn = pixelX[7:0];
                2:       RGBIn = 8'($urandom_range(0, 255));
                default: RGBIn = const_rgb;
            endcase
        end
    end

    task automatic wait_sof(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!startOfFrame && n < FT * CD + 8);
        check(name, 64'(startOfFrame), 64'(1));
    endtask

    task automatic count_to_sof(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!startOfFrame && n < FT * CD + 8);
    endtask

    typedef struct {
        logic [7:0] rgb;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    vec_t vecs[8];

    // ---------------- test sequence ----------------
    initial begin
        int n, bn_n, hs_lo, vs_lo, bad;

        vecs[0] = '{8'hFF,         8'hFF, 8'hFF, 8'hFF};
        vecs[1] = '{8'b101_010_01, 8'hB6, 8'h49, 8'h55};
        vecs[2] = '{8'h00,         8'h00, 8'h00, 8'h00};
        vecs[3] = '{8'b111_000_00, 8'hFF, 8'h00, 8'h00};
        vecs[4] = '{8'b000_111_00, 8'h00, 8'hFF, 8'h00};
        vecs[5] = '{8'b000_000_11, 8'h00, 8'h00, 8'hFF};
        vecs[6] = '{8'b010_010_10, 8'h49, 8'h49, 8'hAA};
        vecs[7] = '{8'b001_110_01, 8'h24, 8'hDB, 8'h55};

        resetN = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 64'({pixTick, pixelX, pixelY, startOfFrame, VGA_HS, VGA_VS,
                                  VGA_BLANK_N, VGA_R, VGA_G, VGA_B}),
              64'({1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0}));
        @(posedge clk);
        #2 resetN = 1'b1;

        // Random pixels: first frame wrap and wrap-to-wrap spacing.
        mode = 2;
        wait_sof("sof_first");
        count_to_sof(n);
        check("sof_spacing", 64'(n), 64'(FT * CD));

        // Fixed colours, read back on a visible pixel.
        mode = 0;
        for (int i = 0; i < 8; i++) begin
            const_rgb = vecs[i].rgb;
            repeat (3 * CD) @(posedge clk);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!VGA_BLANK_N && n < FT * CD);
            check($sformatf("colour[%0d]", i), 64'({VGA_R, VGA_G, VGA_B}),
                  64'({vecs[i].r, vecs[i].g, vecs[i].b}));
        end

        // One-clk mux returning pixelX[7:0]: colour must track the lagged X.
        mode = 1;
        wait_sof("sof_mux_start");
        mux_chk = 1'b1;
        wait_sof("sof_mux_end");
        mux_chk = 1'b0;

        // All-white input over one whole frame: blanking and sync budgets.
        mode = 0;
        const_rgb = 8'hFF;
        wait_sof("sof_white");
        bn_n = 0; hs_lo = 0; vs_lo = 0; bad = 0;
        for (int i = 0; i < FT * CD; i++) begin
            if (i > 0) @(negedge clk);
            bn_n  += int'(VGA_BLANK_N);
            hs_lo += int'(!VGA_HS);
            vs_lo += int'(!VGA_VS);
            if (!VGA_BLANK_N && {VGA_R, VGA_G, VGA_B} != 24'h0) bad++;
            if (VGA_BLANK_N && {VGA_R, VGA_G, VGA_B} != 24'hFFFFFF) bad++;
        end
        @(negedge clk);
        check("sof_after_frame", 64'(startOfFrame), 64'(1));
        check("blank_high_clks", 64'(bn_n), 64'(HA * VA * CD));
        check("hs_low_clks", 64'(hs_lo), 64'(H_SW * CD * VT));
        check("vs_low_clks", 64'(vs_lo), 64'(V_SW * HT * CD));
        check("white_colour_errs", 64'(bad), 64'(0));

        // Reset in the middle of the visible area.
        mode = 2;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(pixelX == 11'(HA / 2) && pixelY == 11'(VA / 2)) && n < FT * CD + 8);
        check("reach_mid_pixel", 64'({pixelX, pixelY}), 64'({11'(HA / 2), 11'(VA / 2)}));
        #1 resetN = 1'b0;
        #1;
        check("reset_mid_async", 64'({pixelX, pixelY, startOfFrame, VGA_HS, VGA_VS,
                                      VGA_BLANK_N, VGA_R, VGA_G, VGA_B}),
              64'({11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0}));
        repeat (3) @(posedge clk);
        #2 resetN = 1'b1;
        @(negedge clk);
        count_to_sof(n);
        check("sof_after_reset", 64'(n), 64'(FT * CD));

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
